// File: rtl/ila_readout_ctrl.sv
// ILA readout sequencer: walks the circular sample buffer from the pre-trigger
// start address and meters nibbles out through the serializer to the SPI slave.
module ila_readout_ctrl #(
  parameter int addr_width   = 12,
  parameter int sample_width = 24,
  parameter int ram_latency  = 1
) (
  input  logic                  i_clk_ILA,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [addr_width-1:0] i_trigger_addr,
  input  logic [addr_width-1:0] i_pre_trigger,
  input  logic [addr_width:0]   i_sample_count,
  input  logic                  i_slave_end_byte_post_edge,
  input  logic                  i_rd,
  output logic [addr_width-1:0] o_ram_addr,
  output logic                  o_read_active,
  output logic                  o_end_byte_strobe,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [addr_width:0]   o_samples_sent
);

  localparam int PPS = ((sample_width - 1) / 4) + 1;
  localparam int SW  = (PPS > 1) ? $clog2(PPS) : 1;
  localparam int NW  = addr_width + 2 + $clog2(PPS);

  localparam logic [NW-1:0]         NIB_ONE  = NW'(1);
  localparam logic [SW-1:0]         SUB_ONE  = SW'(1);
  localparam logic [SW-1:0]         SUB_LAST = SW'(PPS - 1);
  localparam logic [addr_width-1:0] ADDR_ONE = addr_width'(1);
  localparam logic [addr_width:0]   SENT_ONE = (addr_width + 1)'(1);
  localparam logic [1:0]            PRIME_LAST = 2'(ram_latency);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    ACTIVE,
    FINISH
  } state_t;

  state_t          state_q;
  logic [NW-1:0]   nib_q;
  logic [NW-1:0]   total_q;
  logic [NW-1:0]   total_d;
  logic [SW-1:0]   sub_q;
  logic [1:0]      prime_q;
  logic            strobe_fwd;

  assign total_d = NW'(i_sample_count) * NW'(PPS);

  // Abort or reset in the same cycle swallows the slave strobe.
  assign strobe_fwd = i_slave_end_byte_post_edge & (state_q == ACTIVE)
                    & ~i_abort & i_reset;
  assign o_end_byte_strobe = strobe_fwd;

  always_ff @(posedge i_clk_ILA) begin
    if (!i_reset) begin
      state_q        <= IDLE;
      nib_q          <= '0;
      total_q        <= '0;
      sub_q          <= '0;
      prime_q        <= '0;
      o_ram_addr     <= '0;
      o_read_active  <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_samples_sent <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            total_q        <= total_d;
            o_ram_addr     <= i_trigger_addr - i_pre_trigger;
            nib_q          <= '0;
            sub_q          <= '0;
            prime_q        <= '0;
            o_samples_sent <= '0;
            o_busy         <= 1'b1;
            if (i_sample_count == '0) begin
              state_q <= FINISH;
              o_done  <= 1'b1;
            end else begin
              state_q <= PRIME;
            end
          end
        end
        PRIME: begin
          if (i_abort) begin
            state_q       <= IDLE;
            o_busy        <= 1'b0;
            o_read_active <= 1'b0;
          end else if (prime_q == PRIME_LAST) begin
            state_q       <= ACTIVE;
            o_read_active <= 1'b1;
            o_ram_addr    <= o_ram_addr + ADDR_ONE;
          end else begin
            prime_q <= prime_q + 2'd1;
          end
        end
        ACTIVE: begin
          if (i_abort) begin
            state_q       <= IDLE;
            o_busy        <= 1'b0;
            o_read_active <= 1'b0;
          end else begin
            if (i_rd) begin
              o_ram_addr <= o_ram_addr + ADDR_ONE;
            end
            if (strobe_fwd) begin
              nib_q <= nib_q + NIB_ONE;
              if (sub_q == SUB_LAST) begin
                sub_q          <= '0;
                o_samples_sent <= o_samples_sent + SENT_ONE;
              end else begin
                sub_q <= sub_q + SUB_ONE;
              end
              if (nib_q == total_q - NIB_ONE) begin
                state_q       <= FINISH;
                o_read_active <= 1'b0;
                o_done        <= 1'b1;
              end
            end
          end
        end
        FINISH: begin
          state_q       <= IDLE;
          o_busy        <= 1'b0;
          o_read_active <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ila_readout_ctrl.sv
// Directed bench for ila_readout_ctrl: address scoreboard, nibble metering,
// abort/reset/zero-count boundaries and ignored restarts.
module tb_ila_readout_ctrl;

  localparam int AW  = 4;
  localparam int SMW = 24;
  localparam int RL  = 1;
  localparam int PPS = 6;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, strobe, rd;
  logic [AW-1:0] trig, pre;
  logic [AW:0]   cnt;
  logic [AW-1:0] ram_addr;
  logic          read_active, ebs, busy, done;
  logic [AW:0]   sent;

  int n_assert = 0;
  int n_fail   = 0;
  int addr_q[$];
  int cur_addr = 0;
  int cyc = 0;
  int last_strobe = -100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ila_readout_ctrl #(
    .addr_width  (AW),
    .sample_width(SMW),
    .ram_latency (RL)
  ) dut (
    .i_clk_ILA                 (clk),
    .i_reset                   (rst_n),
    .i_start                   (start),
    .i_abort                   (abort),
    .i_trigger_addr            (trig),
    .i_pre_trigger             (pre),
    .i_sample_count            (cnt),
    .i_slave_end_byte_post_edge(strobe),
    .i_rd                      (rd),
    .o_ram_addr                (ram_addr),
    .o_read_active             (read_active),
    .o_end_byte_strobe         (ebs),
    .o_busy                    (busy),
    .o_done                    (done),
    .o_samples_sent            (sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_addr(input string tag);
    if (addr_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      cur_addr = addr_q.pop_front();
      chk(tag, 32'(ram_addr), 32'(cur_addr));
    end
  endtask

  task automatic strobe_on();
    chk("strobe_gap", 32'((cyc - last_strobe) >= RL + 2), 32'd1);
    last_strobe = cyc;
    strobe = 1'b1;
    #1;
  endtask

  // mode: 0 normal, 1 abort at nibble 'at', 2 reset at 'at', 3 restart at 'at'
  task automatic run(input int t, input int p, input int c, input int mode,
                     input int at, input bit start_abort);
    int s;
    int total;
    int used;
    s = (t - p) & ((1 << AW) - 1);
    total = c * PPS;
    if (c > 0) begin
      for (int k = 0; k <= c; k++) addr_q.push_back((s + k) & ((1 << AW) - 1));
    end
    trig = AW'(t);
    pre = AW'(p);
    cnt = (AW + 1)'(c);
    chk("count_legal", 32'(cnt <= (1 << AW)), 32'd1);
    start = 1'b1;
    abort = start_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    if (c == 0) begin
      chk("zero_busy", 32'(busy), 32'd1);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_ra", 32'(read_active), 32'd0);
      strobe_on();
      chk("zero_ebs", 32'(ebs), 32'd0);
      tick();
      strobe = 1'b0;
      chk("zero_busy_end", 32'(busy), 32'd0);
      chk("zero_done_end", 32'(done), 32'd0);
      chk("zero_ra_end", 32'(read_active), 32'd0);
      tick();
      return;
    end
    chk_addr("prime_addr");
    chk("prime_busy", 32'(busy), 32'd1);
    chk("prime_ra", 32'(read_active), 32'd0);
    strobe_on();
    chk("prime_ebs", 32'(ebs), 32'd0);
    tick();
    strobe = 1'b0;
    chk("prime2_ra", 32'(read_active), 32'd0);
    tick();
    chk("active_ra", 32'(read_active), 32'd1);
    chk_addr("active_addr");
    tick();
    for (int n = 0; n < total; n++) begin
      if (mode == 1 && n == at) begin
        abort = 1'b1;
        strobe_on();
        chk("abort_ebs", 32'(ebs), 32'd0);
        tick();
        abort = 1'b0;
        strobe = 1'b0;
        chk("abort_ra", 32'(read_active), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sent", 32'(sent), 32'(at / PPS));
        tick();
        chk("abort_done2", 32'(done), 32'd0);
        chk("abort_sent2", 32'(sent), 32'(at / PPS));
        addr_q.delete();
        return;
      end
      if (mode == 2 && n == at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_ra", 32'(read_active), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sent", 32'(sent), 32'd0);
        chk("rst_ebs", 32'(ebs), 32'd0);
        tick();
        chk("rst_done2", 32'(done), 32'd0);
        addr_q.delete();
        return;
      end
      strobe_on();
      chk("active_ebs", 32'(ebs), 32'd1);
      tick();
      strobe = 1'b0;
      used = 1;
      chk("samples_sent", 32'(sent), 32'((n + 1) / PPS));
      if (n == total - 1) begin
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd1);
        chk("fin_ra", 32'(read_active), 32'd0);
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sent", 32'(sent), 32'(c));
        return;
      end
      chk("run_done", 32'(done), 32'd0);
      chk("run_ra", 32'(read_active), 32'd1);
      if (n % PPS == PPS - 1) begin
        rd = 1'b1;
        tick();
        rd = 1'b0;
        used++;
        chk_addr("rd_addr");
      end
      if (mode == 3 && n == at) begin
        trig = '0;
        pre = '0;
        cnt = (AW + 1)'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        used++;
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_ra", 32'(read_active), 32'd1);
        chk("restart_addr", 32'(ram_addr), 32'(cur_addr));
      end
      while (used < 4) begin
        tick();
        used++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    strobe = 1'b0;
    rd = 1'b0;
    trig = '0;
    pre = '0;
    cnt = '0;
    tick();
    tick();
    chk("reset_addr", 32'(ram_addr), 32'd0);
    chk("reset_ra", 32'(read_active), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sent", 32'(sent), 32'd0);
    chk("reset_ebs", 32'(ebs), 32'd0);
    rst_n = 1'b1;
    strobe_on();
    chk("idle_ebs", 32'(ebs), 32'd0);
    tick();
    strobe = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    tick();
    run(10, 3, 4, 0, 0, 1'b0);
    run(1, 3, 5, 0, 0, 1'b0);
    run(10, 3, 4, 1, 8, 1'b0);
    run(10, 3, 4, 0, 0, 1'b1);
    run(0, 0, 0, 0, 0, 1'b0);
    run(10, 3, 4, 3, 2, 1'b0);
    run(10, 3, 4, 2, 10, 1'b0);
    run(5, 5, 16, 0, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
